id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath, with built-in hazard control.
- Captures the Controller's decoded control bundle, register-file read data, immediate and register specifiers each cycle, and presents them to the EX stage.
- Detects load-use hazards and inserts a bubble.
- Holds EX for a multi-cycle MUL.
- Clears itself on a branch/jump flush.
- Drives Stall back to the PC and IF/ID registers.

---
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register for the 5-stage MIPS datapath with built-in
//   hazard control.
//   - A load followed by a dependent instruction gets one bubble.
//   - A multi-cycle MUL holds EX in place.
//   - A taken branch or jump (Flush) clears the stage.
//
// Ports
//   Clk, Rst_n         clock (rising edge), asynchronous active-low reset
//   ID_Ctrl[13:0]      {RegWrite, ALUOp[3:0], ALUSrc, RegDst[2:0], MemWrite,
//                       MemRead, MemToReg[1:0], JumpReg}, RegWrite at bit 13
//   ID_IsMul           the instruction in ID is a MUL
//   ID_ReadData1/2     rs/rt read data
//   ID_Imm             sign-extended immediate
//   ID_PCPlus4         PC+4 of the instruction in ID
//   ID_Rs/Rt/Rd        register specifiers
//   Flush              squash the instruction in ID (bubble into EX)
//   EX_*               registered copies of the ID_* inputs for the EX stage
//   Stall              hold PC and IF/ID this cycle
//   MulBusy            MUL still occupying EX for more cycles
module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [13:0]       ID_Ctrl,
  input  logic              ID_IsMul,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PCPlus4,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic              Flush,
  output logic [13:0]       EX_Ctrl,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [DATA_W-1:0] EX_PCPlus4,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rd,
  output logic              Stall,
  output logic              MulBusy
);

  // Extra EX cycles a MUL holds after being captured.
  localparam logic [3:0] MUL_LOAD    = 4'(MUL_LATENCY - 1);
  localparam int         MEMREAD_BIT = 3;

  logic [13:0]       ctrl_reg, ctrl_next;
  logic              is_mul_reg, is_mul_next;
  logic [DATA_W-1:0] rd1_reg, rd1_next;
  logic [DATA_W-1:0] rd2_reg, rd2_next;
  logic [DATA_W-1:0] imm_reg, imm_next;
  logic [DATA_W-1:0] pc4_reg, pc4_next;
  logic [4:0]        rs_reg, rs_next;
  logic [4:0]        rt_reg, rt_next;
  logic [4:0]        rd_reg, rd_next;
  logic [3:0]        mul_cnt_reg, mul_cnt_next;

  logic mul_busy;
  logic load_use;

  // The counter is only ever loaded alongside a captured MUL, so gating with
  // is_mul_reg changes nothing functionally; it just keeps the two coherent.
  assign mul_busy = is_mul_reg & (mul_cnt_reg != 4'd0);

  // Loads into $0 are discarded, so they never create a dependency.
  assign load_use = ctrl_reg[MEMREAD_BIT] & (rt_reg != 5'd0) &
                    ((rt_reg == ID_Rs) | (rt_reg == ID_Rt));

  // Built only from registered state and ID inputs: no Stall->Stall loop.
  assign Stall   = mul_busy | load_use;
  assign MulBusy = mul_busy;

  always_comb begin
    // Default: hold everything.
    ctrl_next    = ctrl_reg;
    is_mul_next  = is_mul_reg;
    rd1_next     = rd1_reg;
    rd2_next     = rd2_reg;
    imm_next     = imm_reg;
    pc4_next     = pc4_reg;
    rs_next      = rs_reg;
    rt_next      = rt_reg;
    rd_next      = rd_reg;
    mul_cnt_next = mul_cnt_reg;

    if (Flush) begin
      // A flush also aborts a MUL still in progress.
      ctrl_next    = '0;
      is_mul_next  = 1'b0;
      rd1_next     = '0;
      rd2_next     = '0;
      imm_next     = '0;
      pc4_next     = '0;
      rs_next      = '0;
      rt_next      = '0;
      rd_next      = '0;
      mul_cnt_next = '0;
    end else if (mul_busy) begin
      // Hold has priority over a load-use bubble: the MUL must not be lost.
      mul_cnt_next = mul_cnt_reg - 4'd1;
    end else begin
      // Data is captured even on a load-use bubble; with the control bits
      // zeroed it has no architectural effect.
      rd1_next = ID_ReadData1;
      rd2_next = ID_ReadData2;
      imm_next = ID_Imm;
      pc4_next = ID_PCPlus4;
      rs_next  = ID_Rs;
      rt_next  = ID_Rt;
      rd_next  = ID_Rd;
      if (load_use) begin
        ctrl_next    = '0;
        is_mul_next  = 1'b0;
        mul_cnt_next = '0;
      end else begin
        ctrl_next    = ID_Ctrl;
        is_mul_next  = ID_IsMul;
        mul_cnt_next = ID_IsMul ? MUL_LOAD : 4'd0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl_reg    <= '0;
      is_mul_reg  <= 1'b0;
      rd1_reg     <= '0;
      rd2_reg     <= '0;
      imm_reg     <= '0;
      pc4_reg     <= '0;
      rs_reg      <= '0;
      rt_reg      <= '0;
      rd_reg      <= '0;
      mul_cnt_reg <= '0;
    end else begin
      ctrl_reg    <= ctrl_next;
      is_mul_reg  <= is_mul_next;
      rd1_reg     <= rd1_next;
      rd2_reg     <= rd2_next;
      imm_reg     <= imm_next;
      pc4_reg     <= pc4_next;
      rs_reg      <= rs_next;
      rt_reg      <= rt_next;
      rd_reg      <= rd_next;
      mul_cnt_reg <= mul_cnt_next;
    end
  end

  assign EX_Ctrl      = ctrl_reg;
  assign EX_ReadData1 = rd1_reg;
  assign EX_ReadData2 = rd2_reg;
  assign EX_Imm       = imm_reg;
  assign EX_PCPlus4   = pc4_reg;
  assign EX_Rs        = rs_reg;
  assign EX_Rt        = rt_reg;
  assign EX_Rd        = rd_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed bench for id_ex_stage. Two instances: MUL_LATENCY=3 (main
//   sequence) and MUL_LATENCY=1 (back-to-back MUL sequence). Expected EX
//   contents are pushed to a scoreboard queue when each instruction is
//   driven and popped/compared one cycle later.
module tb_id_ex_stage;

  localparam int DW = 32;

  localparam int CAP  = 0;  // instruction captured as driven
  localparam int HOLD = 1;  // EX keeps previous contents
  localparam int LBUB = 2;  // load-use bubble: data captured, ctrl zero
  localparam int FBUB = 3;  // flush bubble: everything zero

  localparam logic [13:0] C_ADD  = 14'h2000 | (14'd2 << 9);
  localparam logic [13:0] C_LW   = 14'h210A;
  localparam logic [13:0] C_MUL  = 14'h2000 | (14'd5 << 9);
  localparam logic [13:0] C_MULR = C_MUL | 14'h0008;  // MUL with MemRead set

  typedef struct packed {
    logic [13:0] ctrl;
    logic        ismul;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  typedef struct packed {
    logic [13:0] ctrl;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
    logic        busy;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [13:0]   ID_Ctrl = '0;
  logic          ID_IsMul = 1'b0;
  logic [DW-1:0] ID_ReadData1 = '0, ID_ReadData2 = '0, ID_Imm = '0, ID_PCPlus4 = '0;
  logic [4:0]    ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic          Flush = 1'b0;

  logic [13:0]   c3, c1;
  logic [DW-1:0] a3, b3, i3, p3, a1, b1, i1, p1;
  logic [4:0]    rs3, rt3, rd3, rs1, rt1, rd1;
  logic          st3, mb3, st1, mb1;

  logic sel = 1'b0;  // 0: latency-3 instance under check, 1: latency-1

  always #5 Clk = ~Clk;

  id_ex_stage #(.DATA_W(DW), .MUL_LATENCY(3)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Ctrl(ID_Ctrl), .ID_IsMul(ID_IsMul),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .Flush(Flush),
    .EX_Ctrl(c3), .EX_ReadData1(a3), .EX_ReadData2(b3), .EX_Imm(i3),
    .EX_PCPlus4(p3), .EX_Rs(rs3), .EX_Rt(rt3), .EX_Rd(rd3),
    .Stall(st3), .MulBusy(mb3)
  );

  id_ex_stage #(.DATA_W(DW), .MUL_LATENCY(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Ctrl(ID_Ctrl), .ID_IsMul(ID_IsMul),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .Flush(Flush),
    .EX_Ctrl(c1), .EX_ReadData1(a1), .EX_ReadData2(b1), .EX_Imm(i1),
    .EX_PCPlus4(p1), .EX_Rs(rs1), .EX_Rt(rt1), .EX_Rd(rd1),
    .Stall(st1), .MulBusy(mb1)
  );

  exp_t sb_q[$];
  exp_t last_exp = '0;
  int   total = 0;
  int   passed = 0;
  int   pc = 32'h400;

  function automatic exp_t observe(input logic which);
    exp_t o;
    if (which) o = '{ctrl:c1, rd1:a1, rd2:b1, imm:i1, pc4:p1, rs:rs1, rt:rt1, rd:rd1, busy:mb1};
    else       o = '{ctrl:c3, rd1:a3, rd2:b3, imm:i3, pc4:p3, rs:rs3, rt:rt3, rd:rd3, busy:mb3};
    return o;
  endfunction

  function automatic instr_t mk(input logic [13:0] ctrl, input logic ismul,
                                input logic [31:0] d1, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] d,
                                input logic [31:0] pcv);
    instr_t r;
    r.ctrl = ctrl; r.ismul = ismul; r.rd1 = d1; r.rd2 = d1 + 32'd7;
    r.imm = d1 ^ 32'hFFFF_0000; r.pc4 = pcv;
    r.rs = s; r.rt = t; r.rd = d;
    return r;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic check_exp(input string tag, input exp_t obs, input exp_t exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input instr_t in, input logic fl);
    ID_Ctrl = in.ctrl; ID_IsMul = in.ismul;
    ID_ReadData1 = in.rd1; ID_ReadData2 = in.rd2;
    ID_Imm = in.imm; ID_PCPlus4 = in.pc4;
    ID_Rs = in.rs; ID_Rt = in.rt; ID_Rd = in.rd;
    Flush = fl;
  endtask

  // Drive one ID instruction, check Stall for this cycle, clock, then pop
  // the expected EX contents and compare.
  task automatic step(input string tag, input instr_t in, input logic fl,
                      input int act, input logic exp_stall, input logic exp_busy);
    exp_t e;
    exp_t got;
    drive(in, fl);
    case (act)
      CAP:  e = '{ctrl:in.ctrl, rd1:in.rd1, rd2:in.rd2, imm:in.imm, pc4:in.pc4,
                  rs:in.rs, rt:in.rt, rd:in.rd, busy:1'b0};
      HOLD: e = last_exp;
      LBUB: e = '{ctrl:14'h0, rd1:in.rd1, rd2:in.rd2, imm:in.imm, pc4:in.pc4,
                  rs:in.rs, rt:in.rt, rd:in.rd, busy:1'b0};
      default: e = '0;
    endcase
    e.busy = exp_busy;
    last_exp = e;
    sb_q.push_back(e);
    #1;
    check_bit({tag, "_stall"}, sel ? st1 : st3, exp_stall);
    @(posedge Clk);
    #1;
    got = observe(sel);
    e = sb_q.pop_front();
    check_exp({tag, "_ex"}, got, e);
    $display("step %s stall_exp=%0b ctrl=%h rd1=%h busy=%0b", tag, exp_stall, got.ctrl, got.rd1, got.busy);
  endtask

  initial begin
    instr_t add8, add2, mul5;

    // Reset held while ID inputs toggle: everything stays zero.
    for (int k = 0; k < 3; k++) begin
      drive(mk(14'h3FFF ^ 14'(k), 1'b1, 32'hA5A5_0000 + 32'(k), 5'd8, 5'd8, 5'd9, 32'h100), 1'b0);
      @(posedge Clk);
      #1;
      check_exp($sformatf("rst%0d_l3", k), observe(1'b0), '0);
      check_exp($sformatf("rst%0d_l1", k), observe(1'b1), '0);
      check_bit($sformatf("rst%0d_stall_l3", k), st3, 1'b0);
      check_bit($sformatf("rst%0d_stall_l1", k), st1, 1'b0);
    end
    Rst_n = 1'b1;

    // Capture after reset release.
    step("first",   mk(C_ADD, 0, 32'hDEADBEEF, 5'd1, 5'd2, 5'd3, pc), 0, CAP, 0, 0); pc += 4;

    // Load-use with Rt=8: exactly one bubble.
    step("lw8",     mk(C_LW,  0, 32'h0000_1000, 5'd3, 5'd8, 5'd0, pc), 0, CAP, 0, 0); pc += 4;
    add8 = mk(C_ADD, 0, 32'h0000_0808, 5'd8, 5'd9, 5'd10, pc); pc += 4;
    step("lu_bub",  add8, 0, LBUB, 1, 0);
    step("lu_cap",  add8, 0, CAP,  0, 0);

    // Load into $0 never stalls.
    step("lw0",     mk(C_LW,  0, 32'h0000_2000, 5'd4, 5'd0, 5'd0, pc), 0, CAP, 0, 0); pc += 4;
    step("r0_dep",  mk(C_ADD, 0, 32'h0000_0011, 5'd0, 5'd0, 5'd5, pc), 0, CAP, 0, 0); pc += 4;

    // MUL hold: captured, then held two cycles, next captured on the 3rd edge.
    mul5 = mk(C_MUL, 1, 32'd5, 5'd6, 5'd7, 5'd12, pc); pc += 4;
    step("mul",     mul5, 0, CAP, 0, 1);
    add2 = mk(C_ADD, 0, 32'h0000_0222, 5'd10, 5'd11, 5'd13, pc); pc += 4;
    step("mulh1",   add2, 0, HOLD, 1, 1);
    step("mulh2",   add2, 0, HOLD, 1, 0);
    step("mulnext", add2, 0, CAP,  0, 0);

    // Flush on the first busy cycle clears the MUL.
    step("mul_f",   mk(C_MUL, 1, 32'd9, 5'd6, 5'd7, 5'd12, pc), 0, CAP, 0, 1); pc += 4;
    step("mflush",  add2, 1, FBUB, 1, 0);
    step("mf_next", add2, 0, CAP,  0, 0);

    // Flush and load-use together: one bubble, no extra stall afterwards.
    step("lw8b",    mk(C_LW, 0, 32'h0000_3000, 5'd3, 5'd8, 5'd0, pc), 0, CAP, 0, 0); pc += 4;
    step("fl_lu",   add8, 1, FBUB, 1, 0);
    step("fl_next", add8, 0, CAP,  0, 0);

    // Hold beats load-use while the MUL is busy; load-use applies afterwards.
    step("mulr",    mk(C_MULR, 1, 32'd77, 5'd12, 5'd8, 5'd14, pc), 0, CAP, 0, 1); pc += 4;
    step("mr_h1",   add8, 0, HOLD, 1, 1);
    step("mr_h2",   add8, 0, HOLD, 1, 0);
    step("mr_lu",   add8, 0, LBUB, 1, 0);
    step("mr_cap",  add8, 0, CAP,  0, 0);

    // Reset asserted mid-MUL: Stall and MulBusy drop without a clock edge.
    step("mul_r",   mk(C_MUL, 1, 32'd3, 5'd6, 5'd7, 5'd12, pc), 0, CAP, 0, 1); pc += 4;
    Rst_n = 1'b0;
    #1;
    check_bit("midrst_stall", st3, 1'b0);
    check_bit("midrst_busy",  mb3, 1'b0);
    check_exp("midrst_ex", observe(1'b0), '0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    last_exp = '0;

    // MUL_LATENCY=1: back-to-back MULs never stall.
    sel = 1'b1;
    step("l1_mul_a", mk(C_MUL, 1, 32'd11, 5'd1, 5'd2, 5'd3, pc), 0, CAP, 0, 0); pc += 4;
    step("l1_mul_b", mk(C_MUL, 1, 32'd22, 5'd3, 5'd4, 5'd5, pc), 0, CAP, 0, 0); pc += 4;
    step("l1_mul_c", mk(C_MUL, 1, 32'd33, 5'd5, 5'd6, 5'd7, pc), 0, CAP, 0, 0); pc += 4;
    step("l1_add",   mk(C_ADD, 0, 32'd44, 5'd7, 5'd8, 5'd9, pc), 0, CAP, 0, 0); pc += 4;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
